// File: rtl/calc_op_engine_if.sv
// Operation/operand/result bundle between the button path and calc_op_engine.
// CALC_OP_ENGINE_REMAINDER_EN adds the rem_o remainder signal.
interface calc_op_engine_if #(
  parameter int unsigned WIDTH = 8
);
  logic [3:0]         op_i;
  logic [WIDTH-1:0]   a_i;
  logic [WIDTH-1:0]   b_i;
  logic [2*WIDTH-1:0] result_o;
  logic               neg_o;
  logic               err_o;
  logic               done_o;
  logic               busy_o;
  logic [1:0]         last_op_o;
`ifdef CALC_OP_ENGINE_REMAINDER_EN
  logic [WIDTH-1:0]   rem_o;

  modport master (
    output op_i, a_i, b_i,
    input  result_o, neg_o, err_o, done_o, busy_o, last_op_o, rem_o
  );

  modport slave (
    input  op_i, a_i, b_i,
    output result_o, neg_o, err_o, done_o, busy_o, last_op_o, rem_o
  );
`else
  modport master (
    output op_i, a_i, b_i,
    input  result_o, neg_o, err_o, done_o, busy_o, last_op_o
  );

  modport slave (
    input  op_i, a_i, b_i,
    output result_o, neg_o, err_o, done_o, busy_o, last_op_o
  );
`endif
endinterface

// File: rtl/calc_op_engine.sv
// Calculator engine: one-cycle add/sub, iterative shift-add multiply and restoring divide.
// Optional remainder output enabled by CALC_OP_ENGINE_REMAINDER_EN.
module calc_op_engine #(
  parameter int unsigned WIDTH = 8
) (
  input  logic            clk,
  input  logic            rst,
  calc_op_engine_if.slave bus
);

  localparam int unsigned RW = 2 * WIDTH;
  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [RW-1:0]    result_q, result_d;
  logic             neg_q, neg_d;
  logic             err_q, err_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic [1:0]       last_op_q, last_op_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [RW-1:0]    acc_q, acc_d;
  logic [RW-1:0]    mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] divisor_q, divisor_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] part_q, part_d;
  logic [WIDTH-1:0] rem_q, rem_d;

  // Accept decode: highest set bit wins
  logic op_add, op_sub, op_mul, op_div;
  assign op_add = bus.op_i[3];
  assign op_sub = ~bus.op_i[3] & bus.op_i[2];
  assign op_mul = ~bus.op_i[3] & ~bus.op_i[2] & bus.op_i[1];
  assign op_div = ~bus.op_i[3] & ~bus.op_i[2] & ~bus.op_i[1] & bus.op_i[0];

  logic last_iter;
  assign last_iter = (cnt_q == CW'(WIDTH - 1));

  // One multiply step and one restoring-divide step
  logic [RW-1:0]    acc_step;
  logic [WIDTH:0]   trial;
  logic             fits;
  logic [WIDTH-1:0] part_step;
  logic [WIDTH-1:0] quo_step;

  always_comb begin
    acc_step  = acc_q + (mplier_q[0] ? mcand_q : RW'(0));
    trial     = {part_q, quo_q[WIDTH-1]};
    fits      = (trial >= {1'b0, divisor_q});
    part_step = fits ? WIDTH'(trial - {1'b0, divisor_q}) : trial[WIDTH-1:0];
    quo_step  = {quo_q[WIDTH-2:0], fits};
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (op_mul)                         state_d = ST_MUL;
        else if (op_div && (bus.b_i != '0)) state_d = ST_DIV;
      end
      ST_MUL:  if (last_iter) state_d = ST_IDLE;
      ST_DIV:  if (last_iter) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath and output register next values
  always_comb begin
    result_d  = result_q;
    neg_d     = neg_q;
    err_d     = err_q;
    done_d    = 1'b0;
    busy_d    = busy_q;
    last_op_d = last_op_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    divisor_d = divisor_q;
    quo_d     = quo_q;
    part_d    = part_q;
    rem_d     = rem_q;

    unique case (state_q)
      ST_IDLE: begin
        if (op_add) begin
          result_d  = RW'(bus.a_i) + RW'(bus.b_i);
          neg_d     = 1'b0;
          err_d     = 1'b0;
          last_op_d = 2'd0;
          done_d    = 1'b1;
          rem_d     = '0;
        end else if (op_sub) begin
          result_d  = (bus.a_i >= bus.b_i) ? RW'(bus.a_i - bus.b_i) : RW'(bus.b_i - bus.a_i);
          neg_d     = (bus.a_i < bus.b_i);
          err_d     = 1'b0;
          last_op_d = 2'd1;
          done_d    = 1'b1;
          rem_d     = '0;
        end else if (op_mul) begin
          acc_d    = '0;
          mcand_d  = RW'(bus.a_i);
          mplier_d = bus.b_i;
          cnt_d    = '0;
          busy_d   = 1'b1;
        end else if (op_div) begin
          if (bus.b_i == '0) begin
            result_d  = '0;
            neg_d     = 1'b0;
            err_d     = 1'b1;
            last_op_d = 2'd3;
            done_d    = 1'b1;
            rem_d     = '0;
          end else begin
            part_d    = '0;
            quo_d     = bus.a_i;
            divisor_d = bus.b_i;
            cnt_d     = '0;
            busy_d    = 1'b1;
          end
        end
      end
      ST_MUL: begin
        acc_d    = acc_step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        if (last_iter) begin
          result_d  = acc_step;
          neg_d     = 1'b0;
          err_d     = 1'b0;
          last_op_d = 2'd2;
          done_d    = 1'b1;
          busy_d    = 1'b0;
          cnt_d     = '0;
          rem_d     = '0;
        end
      end
      ST_DIV: begin
        part_d = part_step;
        quo_d  = quo_step;
        cnt_d  = cnt_q + CW'(1);
        if (last_iter) begin
          result_d  = RW'(quo_step);
          neg_d     = 1'b0;
          err_d     = 1'b0;
          last_op_d = 2'd3;
          done_d    = 1'b1;
          busy_d    = 1'b0;
          cnt_d     = '0;
          rem_d     = part_step;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      result_q  <= '0;
      neg_q     <= 1'b0;
      err_q     <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      last_op_q <= '0;
      cnt_q     <= '0;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      divisor_q <= '0;
      quo_q     <= '0;
      part_q    <= '0;
      rem_q     <= '0;
    end else begin
      result_q  <= result_d;
      neg_q     <= neg_d;
      err_q     <= err_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      last_op_q <= last_op_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      divisor_q <= divisor_d;
      quo_q     <= quo_d;
      part_q    <= part_d;
      rem_q     <= rem_d;
    end
  end

  assign bus.result_o  = result_q;
  assign bus.neg_o     = neg_q;
  assign bus.err_o     = err_q;
  assign bus.done_o    = done_q;
  assign bus.busy_o    = busy_q;
  assign bus.last_op_o = last_op_q;
`ifdef CALC_OP_ENGINE_REMAINDER_EN
  assign bus.rem_o     = rem_q;
`else
  logic unused_rem;
  assign unused_rem = ^rem_q;
`endif

endmodule

// File: tb/tb_calc_op_engine.sv
// Directed scoreboard bench for calc_op_engine (WIDTH=8).
module tb_calc_op_engine;
  localparam int unsigned W = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  calc_op_engine_if #(.WIDTH(W)) bus ();
  calc_op_engine #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [2*W-1:0] res;
    logic           neg;
    logic           err;
    logic [1:0]     lop;
    logic [W-1:0]   rem;
  } exp_t;

  exp_t sb[$];
  int compared   = 0;
  int mismatched = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one op pulse, wait for done, compare against the scoreboard head.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input int inj, input bit tail);
    exp_t e, got;
    int lat, c;
    bit iter;
    e.neg = 1'b0; e.err = 1'b0; e.rem = '0; e.res = '0; e.lop = 2'd0;
    iter = 1'b0; lat = 1;
    if (op[3]) begin
      e.res = (2*W)'(a) + (2*W)'(b); e.lop = 2'd0;
    end else if (op[2]) begin
      e.res = (a >= b) ? (2*W)'(a - b) : (2*W)'(b - a);
      e.neg = (a < b); e.lop = 2'd1;
    end else if (op[1]) begin
      e.res = (2*W)'(a) * (2*W)'(b); e.lop = 2'd2; iter = 1'b1; lat = W + 1;
    end else if (b == '0) begin
      e.err = 1'b1; e.lop = 2'd3;
    end else begin
      e.res = (2*W)'(a / b); e.rem = a % b; e.lop = 2'd3; iter = 1'b1; lat = W + 1;
    end
    sb.push_back(e);

    bus.op_i = op; bus.a_i = a; bus.b_i = b;
    c = 0;
    while (c < 40) begin
      tick();
      c++;
      bus.op_i = (c == inj) ? 4'b1000 : 4'b0000;
      bus.a_i  = W'($urandom);
      bus.b_i  = W'($urandom);
      if (bus.done_o === 1'b1) break;
      check({tag, "_busy"}, 32'(bus.busy_o), 32'(iter));
    end
    bus.op_i = 4'b0000;
    check({tag, "_latency"}, 32'(c), 32'(lat));
    got = sb.pop_front();
    check({tag, "_result"}, 32'(bus.result_o), 32'(got.res));
    check({tag, "_neg"},    32'(bus.neg_o),    32'(got.neg));
    check({tag, "_err"},    32'(bus.err_o),    32'(got.err));
    check({tag, "_lastop"}, 32'(bus.last_op_o), 32'(got.lop));
    check({tag, "_busy_end"}, 32'(bus.busy_o), 32'(0));
`ifdef CALC_OP_ENGINE_REMAINDER_EN
    check({tag, "_rem"},    32'(bus.rem_o),    32'(got.rem));
`endif
    if (tail) begin
      tick();
      check({tag, "_done_1cyc"}, 32'(bus.done_o), 32'(0));
      check({tag, "_hold"}, 32'(bus.result_o), 32'(got.res));
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_result"}, 32'(bus.result_o), 32'(0));
    check({tag, "_neg"},    32'(bus.neg_o),    32'(0));
    check({tag, "_err"},    32'(bus.err_o),    32'(0));
    check({tag, "_done"},   32'(bus.done_o),   32'(0));
    check({tag, "_busy"},   32'(bus.busy_o),   32'(0));
    check({tag, "_lastop"}, 32'(bus.last_op_o), 32'(0));
`ifdef CALC_OP_ENGINE_REMAINDER_EN
    check({tag, "_rem"},    32'(bus.rem_o),    32'(0));
`endif
  endtask

  initial begin
    rst = 1'b1;
    bus.op_i = 4'b0000; bus.a_i = '0; bus.b_i = '0;
    tick(); tick(); tick();
    check_zero("reset");
    rst = 1'b0;
    tick();

    run_op("add_200_100", 4'b1000, 8'd200, 8'd100, 0, 1'b1);
    run_op("sub_5_9",     4'b0100, 8'd5,   8'd9,   0, 1'b1);
    run_op("sub_9_5",     4'b0100, 8'd9,   8'd5,   0, 1'b1);
    run_op("mul_ff_ff",   4'b0010, 8'd255, 8'd255, 4, 1'b1);
    run_op("div_200_7",   4'b0001, 8'd200, 8'd7,   0, 1'b1);
    run_op("div_by_zero", 4'b0001, 8'd13,  8'd0,   0, 1'b1);
    // Next op is issued in the cycle done_o is high
    run_op("prio_add",    4'b1010, 8'd3,   8'd4,   0, 1'b0);
    run_op("b2b_sub",     4'b0100, 8'd10,  8'd3,   0, 1'b1);
    run_op("mul_13_11",   4'b0011, 8'd13,  8'd11,  0, 1'b1);
    run_op("mul_x_0",     4'b0010, 8'd77,  8'd0,   0, 1'b1);
    run_op("div_255_1",   4'b0001, 8'd255, 8'd1,   0, 1'b1);
    run_op("div_5_200",   4'b0001, 8'd5,   8'd200, 0, 1'b1);
    run_op("add_max",     4'b1000, 8'd255, 8'd255, 0, 1'b1);
    run_op("sub_equal",   4'b0100, 8'd42,  8'd42,  0, 1'b1);

    // Reset in the middle of a divide aborts it
    bus.op_i = 4'b0001; bus.a_i = 8'd200; bus.b_i = 8'd7;
    tick();
    bus.op_i = 4'b0000;
    check("mid_div_busy", 32'(bus.busy_o), 32'(1));
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_zero("mid_reset");
    for (int i = 0; i < W + 2; i++) begin
      tick();
      check("no_done_after_abort", 32'(bus.done_o), 32'(0));
    end
    run_op("add_after_rst", 4'b1000, 8'd3, 8'd4, 0, 1'b1);

    check("sb_empty", 32'(sb.size()), 32'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
